// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the Wishbone master arbiter.
package wb_arb_pkg;

    localparam int unsigned MAX_MASTERS = 4;
    localparam int unsigned WB_ADR_W    = 32;
    localparam int unsigned WB_DAT_W    = 32;
    localparam int unsigned WB_SEL_W    = 4;

    typedef logic [1:0] grant_idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  grant_idx_t             last_grant,
    output logic                   valid,
    output grant_idx_t             idx
);

    logic [MAX_MASTERS-1:0] req_ext;
    int unsigned            cand;

    always_comb begin
        req_ext                    = '0;
        req_ext[NUM_MASTERS-1:0]   = req;
        valid                      = 1'b0;
        idx                        = '0;
        cand                       = 0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!valid && req_ext[grant_idx_t'(cand)]) begin
                valid = 1'b1;
                idx   = grant_idx_t'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among up to four masters.
// Define WB_ARB_TIMEOUT_EN to enable the no-ACK watchdog.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          i_m_cyc,
    input  logic [NUM_MASTERS-1:0]          i_m_stb,
    input  logic [NUM_MASTERS-1:0]          i_m_we,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] i_m_sel,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] i_m_adr,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] i_m_dat,
    output logic [NUM_MASTERS-1:0]          o_m_ack,
    output logic [NUM_MASTERS-1:0]          o_m_err,
    output logic [WB_DAT_W-1:0]             o_m_dat,
    output logic                            o_s_cyc,
    output logic                            o_s_stb,
    output logic                            o_s_we,
    output logic [WB_SEL_W-1:0]             o_s_sel,
    output logic [WB_ADR_W-1:0]             o_s_adr,
    output logic [WB_DAT_W-1:0]             o_s_dat,
    input  logic                            i_s_ack,
    input  logic [WB_DAT_W-1:0]             i_s_dat,
    output grant_idx_t                      o_grant,
    output logic                            o_busy
);

    arb_state_t state;
    grant_idx_t grant;
    grant_idx_t last_grant;
    logic       pick_valid;
    grant_idx_t pick_idx;
    logic       own;
    logic       tmo;

    wb_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req       (i_m_cyc),
        .last_grant(last_grant),
        .valid     (pick_valid),
        .idx       (pick_idx)
    );

    assign own     = (state == OWN);
    assign o_busy  = own;
    assign o_grant = own ? grant : '0;
    assign o_m_dat = i_s_dat;

    // Slave side is a pure mux of the owner so reset drops it without an edge.
    always_comb begin
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_s_we  = 1'b0;
        o_s_sel = '0;
        o_s_adr = '0;
        o_s_dat = '0;
        o_m_ack = '0;
        if (own) begin
            for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                if (grant == grant_idx_t'(k)) begin
                    o_s_cyc    = i_m_cyc[k];
                    o_s_stb    = i_m_stb[k];
                    o_s_we     = i_m_we[k];
                    o_s_sel    = i_m_sel[k*WB_SEL_W +: WB_SEL_W];
                    o_s_adr    = i_m_adr[k*WB_ADR_W +: WB_ADR_W];
                    o_s_dat    = i_m_dat[k*WB_DAT_W +: WB_DAT_W];
                    o_m_ack[k] = i_s_ack;
                end
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    assign tmo = own && !i_s_ack && (wd_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero outside OWN, which also covers the clear on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (!own || i_s_ack) begin
            wd_cnt <= '0;
        end else if (o_s_stb) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        o_m_err = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (tmo && (grant == grant_idx_t'(k))) begin
                o_m_err[k] = 1'b1;
            end
        end
    end
`else
    assign tmo     = 1'b0;
    assign o_m_err = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= grant_idx_t'(NUM_MASTERS - 1);
        end else if (state == IDLE) begin
            if (pick_valid) begin
                grant <= pick_idx;
                state <= OWN;
            end
        end else begin
            if (!o_s_cyc || tmo) begin
                state      <= IDLE;
                last_grant <= grant;
            end
        end
    end

endmodule
